user_to_dest_map: RTL and testbench
===================================

# user_to_dest_map

Packet-aware AXI4-Stream stage that converts the per-beat traffic-class tag on `s_axis_tuser` into an output `m_axis_tdest` through a runtime-programmable lookup table, for the CBS queue-select path in front of the per-class shapers. The destination is resolved on the first beat of each packet and held constant until `tlast`, so tdest never changes inside a packet. Data passes through a full-throughput registered skid stage. Per-destination packet counters are provided for statistics.

## Interface
- `C_AXIS_TDATA_WIDTH`, 8: data width in bits.
- `C_AXIS_TKEEP_WIDTH`, `C_AXIS_TDATA_WIDTH/8`: tkeep width.
- `C_AXIS_TUSER_WIDTH`, 3: class tag width (PCP); table has `2**C_AXIS_TUSER_WIDTH` entries.
- `C_AXIS_TDEST_WIDTH`, 2: destination width; `2**C_AXIS_TDEST_WIDTH` destinations.
- `C_CNT_WIDTH`, 32: width of each packet counter.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tuser`  in/in/in/out/in/in  per parameters  input stream.
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tdest`  out/out/out/in/out/out  per parameters  output stream.
- `cfg_map`  in  `2**C_AXIS_TUSER_WIDTH * C_AXIS_TDEST_WIDTH`  table; entry i at bits `[i*TDEST_W +: TDEST_W]`.
- `stat_pkt_cnt`  out  `2**C_AXIS_TDEST_WIDTH * C_CNT_WIDTH`  packets emitted per destination; entry d at `[d*C_CNT_WIDTH +: C_CNT_WIDTH]`.

## Operation
- Packet state machine, input side, advances only on input handshake (`s_axis_tvalid && s_axis_tready`):
  - FIRST: beat is first of packet; resolved dest = `cfg_map[s_axis_tuser]`. If `tlast=0`, latch dest into `dest_q` and go to BODY; if `tlast=1` (single-beat packet), stay in FIRST.
  - BODY: beat uses `dest_q`; `s_axis_tuser` and `cfg_map` ignored. On `tlast=1` go to FIRST.
- `cfg_map` sampled only in FIRST at the handshake; changes mid-packet affect only the next packet.
- Beat fields (tdata, tkeep, tlast, resolved tdest) enter a 2-entry skid stage; output fields come only from registers.
- Counter d increments by 1 on each output handshake with `m_axis_tlast=1` and `m_axis_tdest=d`; wraps to 0 after all-ones; no saturation.
- No beat is dropped, duplicated or reordered. tkeep passes unmodified.

## Timing
- Reset (async assert, sync release): `m_axis_tvalid=0`, `m_axis_tdata/tkeep/tlast/tdest=0`, `s_axis_tready=0`, all counters 0, state FIRST, skid empty.
- `s_axis_tready` rises on the first `clk` edge after `rst` deasserts.
- Latency 1 cycle input handshake to `m_axis_tvalid`; sustained 1 beat/cycle when `m_axis_tready=1`.
- `s_axis_tready` is registered: 1 whenever skid holds <2 beats after the current edge; no combinational path from `m_axis_tready` to `s_axis_tready`.
- Backpressure: `m_axis_tready=0` with valid output → output fields held stable; at most one further beat accepted, then `s_axis_tready=0`.
- Simultaneous input and output handshake with skid at 1 entry: occupancy unchanged, tready stays 1.
- Counter updates are visible on `stat_pkt_cnt` the cycle after the counting handshake.
- `rst` mid-packet: partial packet discarded, state to FIRST, outputs to reset values immediately.

## Structure
- Shared package `cbs_pkg`: default map constant (identity-modulo mapping of PCP to destination), counter width default, tag/dest width defaults.
- One sub-module: `axis_skid_buffer` (2-entry register slice, parametrised payload width), instantiated with payload `{tdest, tlast, tkeep, tdata}`.
- FSM, dest latch and counter bank stay in `user_to_dest_map`.

## Test plan
- Identity map, 3-beat packets with tuser 5 on beat 1 and tuser 0/7 on beats 2–3, `m_axis_tready=1` -> all 3 output beats tdest=1 (map[5]=1 for 2-bit dest identity-mod), data unchanged, 1-cycle latency, `stat_pkt_cnt[1]`=1.
- Rewrite `cfg_map[2]` from 0 to 3 during beat 2 of a tuser=2 packet -> current packet tdest=0 on all beats, next tuser=2 packet tdest=3.
- Back-to-back single-beat packets tuser 0..7, map i->i%4 -> tdest sequence 0,1,2,3,0,1,2,3, each counter =2, no bubbles.
- Random `m_axis_tready` (50%) with continuous input, 1000 beats -> scoreboard match, outputs stable while stalled, never >2 beats buffered, `s_axis_tready` low only when full.
- Preload counter 0 to all-ones via 2**C_CNT_WIDTH packets (bench with `C_CNT_WIDTH=4`, 16 packets) -> counter 0 reads 0, others unaffected.
- Assert `rst` mid-packet for 1 cycle -> `m_axis_tvalid=0` and counters 0 immediately, `s_axis_tready=1` one edge after release, next beat treated as FIRST.

Source files
------------

// File: rtl/cbs_pkg.sv
// Shared constants for the CBS queue-select path: default tag/dest/counter
// widths and the default PCP-to-destination map.
// Default map is identity-modulo: class i goes to destination i % 2**CBS_TDEST_W.
package cbs_pkg;

    localparam int CBS_TUSER_W = 3;
    localparam int CBS_TDEST_W = 2;
    localparam int CBS_CNT_W   = 32;
    localparam int CBS_MAP_W   = (2 ** CBS_TUSER_W) * CBS_TDEST_W;

    // Truncating the class index to the dest width gives the modulo mapping.
    function automatic logic [CBS_MAP_W-1:0] cbs_identity_map();
        logic [CBS_MAP_W-1:0] m;
        m = '0;
        for (int i = 0; i < 2 ** CBS_TUSER_W; i++) begin
            m[i*CBS_TDEST_W +: CBS_TDEST_W] = CBS_TDEST_W'(i);
        end
        return m;
    endfunction

    localparam logic [CBS_MAP_W-1:0] CBS_DEFAULT_MAP = cbs_identity_map();

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: output register plus one skid register.
// Latency: 1 cycle from input handshake to m_valid_o; 1 beat/cycle sustained.
// Backpressure: s_ready_o is registered and drops only when both entries are full.
// Ports: clk/rst (async active-high), s_* upstream valid/ready/data,
//        m_* downstream valid/ready/data (driven straight from registers).
module axis_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o
);

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
    logic              rdy_q, rdy_d;

    logic in_hs;
    logic out_hs;

    assign in_hs  = s_valid_i && rdy_q;
    assign out_hs = out_vld_q && m_ready_i;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (out_hs || !out_vld_q) begin
            // Output register is free this edge: refill from skid first to
            // keep ordering, otherwise directly from the input.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = in_hs;
                if (in_hs) begin
                    skid_dat_d = s_data_i;
                end
            end else begin
                out_vld_d = in_hs;
                if (in_hs) begin
                    out_dat_d = s_data_i;
                end
            end
        end else if (in_hs) begin
            // Output stalled: park the accepted beat in the skid register.
            skid_vld_d = 1'b1;
            skid_dat_d = s_data_i;
        end
        // Ready for the next cycle depends only on next-state occupancy, so
        // there is no combinational path from m_ready_i to s_ready_o.
        rdy_d = !(out_vld_d && skid_vld_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_ready_o = rdy_q;
    assign m_valid_o = out_vld_q;
    assign m_data_o  = out_dat_q;

endmodule

// File: rtl/user_to_dest_map.sv
// AXI4-Stream stage mapping the first-beat tuser class to a per-packet tdest
// through cfg_map, with per-destination packet counters on stat_pkt_cnt.
// Latency: 1 cycle via axis_skid_buffer; full throughput.
// Backpressure: s_axis_tready registered, low only when the 2-entry skid is full.
// Ports: clk/rst (async active-high), s_axis_* input stream, m_axis_* output
//        stream, cfg_map lookup table, stat_pkt_cnt packet counters.
module user_to_dest_map
    import cbs_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int C_AXIS_TUSER_WIDTH = CBS_TUSER_W,
    parameter int C_AXIS_TDEST_WIDTH = CBS_TDEST_W,
    parameter int C_CNT_WIDTH        = CBS_CNT_W
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]                    s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0]                    s_axis_tkeep,
    input  logic                                             s_axis_tvalid,
    output logic                                             s_axis_tready,
    input  logic                                             s_axis_tlast,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                    s_axis_tuser,
    output logic [C_AXIS_TDATA_WIDTH-1:0]                    m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0]                    m_axis_tkeep,
    output logic                                             m_axis_tvalid,
    input  logic                                             m_axis_tready,
    output logic                                             m_axis_tlast,
    output logic [C_AXIS_TDEST_WIDTH-1:0]                    m_axis_tdest,
    input  logic [(2**C_AXIS_TUSER_WIDTH)*C_AXIS_TDEST_WIDTH-1:0] cfg_map,
    output logic [(2**C_AXIS_TDEST_WIDTH)*C_CNT_WIDTH-1:0]   stat_pkt_cnt
);

    localparam int NUM_CLS  = 2 ** C_AXIS_TUSER_WIDTH;
    localparam int NUM_DEST = 2 ** C_AXIS_TDEST_WIDTH;
    localparam int PAY_W    = C_AXIS_TDEST_WIDTH + 1 + C_AXIS_TKEEP_WIDTH + C_AXIS_TDATA_WIDTH;

    localparam logic [0:0] ST_FIRST = 1'b0;
    localparam logic [0:0] ST_BODY  = 1'b1;

    logic [C_AXIS_TDEST_WIDTH-1:0] map_tbl [NUM_CLS];

    for (genvar i = 0; i < NUM_CLS; i++) begin : g_map
        assign map_tbl[i] = cfg_map[i*C_AXIS_TDEST_WIDTH +: C_AXIS_TDEST_WIDTH];
    end

    logic [0:0]                    state_q, state_d;
    logic [C_AXIS_TDEST_WIDTH-1:0] dest_q, dest_d;
    logic [C_AXIS_TDEST_WIDTH-1:0] beat_dest;
    logic                          in_hs;
    logic                          out_hs;

    assign in_hs  = s_axis_tvalid && s_axis_tready;
    assign out_hs = m_axis_tvalid && m_axis_tready;

    // The table is consulted only on a packet's first beat; body beats reuse
    // the latched dest so tdest is constant across the packet even if
    // cfg_map or tuser change mid-packet.
    assign beat_dest = (state_q == ST_FIRST) ? map_tbl[s_axis_tuser] : dest_q;

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        if (in_hs) begin
            case (state_q)
                ST_FIRST: begin
                    if (!s_axis_tlast) begin
                        state_d = ST_BODY;
                        dest_d  = beat_dest;
                    end
                end
                ST_BODY: begin
                    if (s_axis_tlast) begin
                        state_d = ST_FIRST;
                    end
                end
                default: state_d = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FIRST;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    logic [PAY_W-1:0] skid_in;
    logic [PAY_W-1:0] skid_out;

    assign skid_in = {beat_dest, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    axis_skid_buffer #(
        .DATA_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (s_axis_tvalid),
        .s_ready_o (s_axis_tready),
        .s_data_i  (skid_in),
        .m_valid_o (m_axis_tvalid),
        .m_ready_i (m_axis_tready),
        .m_data_o  (skid_out)
    );

    assign {m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = skid_out;

    // Packed 2-D layout puts counter d at bits [d*C_CNT_WIDTH +: C_CNT_WIDTH].
    logic [NUM_DEST-1:0][C_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && m_axis_tlast) begin
            // Free-running wrap: no saturation.
            cnt_d[m_axis_tdest] = cnt_q[m_axis_tdest] + C_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_pkt_cnt = cnt_q;

endmodule

// File: tb/tb_user_to_dest_map.sv
// Self-checking bench for user_to_dest_map: vector table for directed packets,
// scoreboard queue for every output beat, occupancy/stall checks under
// random backpressure, counter wrap and mid-packet reset sequences.
module tb_user_to_dest_map;
    import cbs_pkg::*;

    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 3;
    localparam int TW = 2;
    localparam int CW = 4;
    localparam int ND = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DW-1:0]        s_axis_tdata = '0;
    logic [KW-1:0]        s_axis_tkeep = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tready;
    logic                 s_axis_tlast = 1'b0;
    logic [UW-1:0]        s_axis_tuser = '0;
    logic [DW-1:0]        m_axis_tdata;
    logic [KW-1:0]        m_axis_tkeep;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready = 1'b1;
    logic                 m_axis_tlast;
    logic [TW-1:0]        m_axis_tdest;
    logic [(2**UW)*TW-1:0] cfg_map = CBS_DEFAULT_MAP;
    logic [ND*CW-1:0]     stat_pkt_cnt;

    always #5 clk = ~clk;

    user_to_dest_map #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_AXIS_TKEEP_WIDTH (KW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_AXIS_TDEST_WIDTH (TW),
        .C_CNT_WIDTH        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .cfg_map       (cfg_map),
        .stat_pkt_cnt  (stat_pkt_cnt)
    );

    typedef struct packed {
        logic [TW-1:0] dest;
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] dat;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
        logic [UW-1:0] user;
        logic [TW-1:0] dest;
    } vec_t;

    int      n_chk  = 0;
    int      n_pass = 0;
    beat_t   sb[$];
    logic [CW-1:0] exp_cnt [ND];
    logic    chk_en  = 1'b0;
    logic    rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int d);
        return stat_pkt_cnt[d*CW +: CW];
    endfunction

    task automatic check_cnts(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_cnt%0d", tag, d), 32'(cnt_of(d)), 32'(exp_cnt[d]));
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, record the expected
    // output beat. Returns at posedge+1 with tvalid dropped.
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                        input logic [UW-1:0] u, input logic [TW-1:0] e, output int waits);
        beat_t b;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!s_axis_tready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            chk("send_ready_timeout", 32'(s_axis_tready), 32'd1);
        end else begin
            b = '{dest: e, last: l, keep: k, dat: d};
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; asserts reset and checks outputs clear immediately.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_fields", 32'({m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 32'd0);
        chk("rst_stat", 32'(stat_pkt_cnt), 32'd0);
        sb.delete();
        for (int d = 0; d < ND; d++) exp_cnt[d] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_tready_low", 32'(s_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rel_tready_high", 32'(s_axis_tready), 32'd1);
    endtask

    task automatic monitor();
        beat_t got;
        beat_t e;
        beat_t stall_b;
        logic  prev_stall;
        logic  have_prev;
        int    occ;
        prev_stall = 1'b0;
        have_prev  = 1'b0;
        occ        = 0;
        stall_b    = '0;
        forever begin
            @(negedge clk);
            got = '{m_axis_tdest, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (!rst && m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_beat", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_beat", 32'(got), 32'(e));
                    if (e.last) exp_cnt[e.dest] = exp_cnt[e.dest] + 1'b1;
                end
            end
            if (chk_en && !rst) begin
                if (prev_stall) begin
                    chk("stall_hold", 32'({m_axis_tvalid, got}), 32'({1'b1, stall_b}));
                end
                if (have_prev) begin
                    chk("occ_tready", 32'(s_axis_tready), 32'(occ < 2));
                    chk("occ_tvalid", 32'(m_axis_tvalid), 32'(occ > 0));
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                stall_b    = got;
                occ = occ + int'(s_axis_tvalid && s_axis_tready) - int'(m_axis_tvalid && m_axis_tready);
                have_prev = 1'b1;
            end else begin
                prev_stall = 1'b0;
                have_prev  = 1'b0;
                occ        = 0;
            end
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [11];
        int   w;
        logic [UW-1:0] u;
        logic [TW-1:0] pdest;
        int   plen;
        int   pos;

        // Packet A: 3 beats, class 5 on the first beat -> dest 1 throughout.
        tbl[0] = '{dat: 8'hA1, last: 1'b0, user: 3'd5, dest: 2'd1};
        tbl[1] = '{dat: 8'hB2, last: 1'b0, user: 3'd0, dest: 2'd1};
        tbl[2] = '{dat: 8'hC3, last: 1'b1, user: 3'd7, dest: 2'd1};
        // Single-beat packets class 0..7 -> dest i%4.
        tbl[3]  = '{dat: 8'h10, last: 1'b1, user: 3'd0, dest: 2'd0};
        tbl[4]  = '{dat: 8'h11, last: 1'b1, user: 3'd1, dest: 2'd1};
        tbl[5]  = '{dat: 8'h12, last: 1'b1, user: 3'd2, dest: 2'd2};
        tbl[6]  = '{dat: 8'h13, last: 1'b1, user: 3'd3, dest: 2'd3};
        tbl[7]  = '{dat: 8'h14, last: 1'b1, user: 3'd4, dest: 2'd0};
        tbl[8]  = '{dat: 8'h15, last: 1'b1, user: 3'd5, dest: 2'd1};
        tbl[9]  = '{dat: 8'h16, last: 1'b1, user: 3'd6, dest: 2'd2};
        tbl[10] = '{dat: 8'h17, last: 1'b1, user: 3'd7, dest: 2'd3};

        for (int d = 0; d < ND; d++) exp_cnt[d] = '0;
        fork
            monitor();
            ready_gen();
        join_none

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed 3-beat packet, 1-cycle latency per beat.
        for (int i = 0; i < 3; i++) begin
            send(tbl[i].dat, tbl[i].dat[0 +: KW], tbl[i].last, tbl[i].user, tbl[i].dest, w);
            chk($sformatf("lat_vld_%0d", i), 32'(m_axis_tvalid), 32'd1);
            chk($sformatf("lat_dat_%0d", i), 32'(m_axis_tdata), 32'(tbl[i].dat));
            chk($sformatf("lat_dest_%0d", i), 32'(m_axis_tdest), 32'(tbl[i].dest));
        end
        drain();
        chk("pktA_cnt1", 32'(cnt_of(1)), 32'd1);
        check_cnts("pktA");

        // Back-to-back single-beat packets, no bubbles.
        do_reset();
        for (int i = 3; i < 11; i++) begin
            send(tbl[i].dat, tbl[i].dat[0 +: KW], tbl[i].last, tbl[i].user, tbl[i].dest, w);
            chk($sformatf("nobubble_%0d", i), 32'(w), 32'd0);
            chk($sformatf("b2b_dest_%0d", i), 32'(m_axis_tdest), 32'(tbl[i].dest));
        end
        drain();
        for (int d = 0; d < ND; d++) chk($sformatf("b2b_cnt%0d", d), 32'(cnt_of(d)), 32'd2);

        // Map rewrite mid-packet affects only the next packet.
        do_reset();
        cfg_map = CBS_DEFAULT_MAP;
        cfg_map[2*TW +: TW] = 2'd0;
        send(8'h21, 1'b1, 1'b0, 3'd2, 2'd0, w);
        cfg_map[2*TW +: TW] = 2'd3;
        send(8'h22, 1'b0, 1'b0, 3'd2, 2'd0, w);
        send(8'h23, 1'b1, 1'b1, 3'd2, 2'd0, w);
        send(8'h24, 1'b0, 1'b1, 3'd2, 2'd3, w);
        drain();
        chk("remap_cnt0", 32'(cnt_of(0)), 32'd1);
        chk("remap_cnt3", 32'(cnt_of(3)), 32'd1);
        check_cnts("remap");
        cfg_map = CBS_DEFAULT_MAP;

        // Counter wrap after 2**CW packets.
        do_reset();
        for (int i = 0; i < 15; i++) send(8'(i), 1'b1, 1'b1, 3'd4, 2'd0, w);
        drain();
        chk("wrap_cnt0_15", 32'(cnt_of(0)), 32'd15);
        send(8'h3F, 1'b1, 1'b1, 3'd0, 2'd0, w);
        drain();
        chk("wrap_cnt0_0", 32'(cnt_of(0)), 32'd0);
        chk("wrap_others", 32'(stat_pkt_cnt[ND*CW-1:CW]), 32'd0);

        // Random backpressure, continuous input, random packet lengths.
        do_reset();
        chk_en  = 1'b1;
        rnd_rdy = 1'b1;
        pos = 0;
        plen = 0;
        pdest = '0;
        for (int n = 0; n < 1000; n++) begin
            u = 3'($urandom_range(0, 7));
            if (pos == 0) begin
                plen  = $urandom_range(1, 4);
                pdest = u[TW-1:0];
            end
            pos++;
            send(8'($urandom), 1'($urandom), (pos == plen), u, pdest, w);
            if (pos == plen) pos = 0;
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        drain();
        chk_en = 1'b0;
        check_cnts("rand");

        // Reset in the middle of a packet.
        do_reset();
        send(8'h51, 1'b1, 1'b1, 3'd1, 2'd1, w);
        drain();
        chk("prerst_cnt1", 32'(cnt_of(1)), 32'd1);
        m_axis_tready = 1'b0;
        send(8'h52, 1'b1, 1'b0, 3'd3, 2'd3, w);
        do_reset();
        m_axis_tready = 1'b1;
        send(8'h61, 1'b0, 1'b1, 3'd1, 2'd1, w);
        chk("postrst_dest", 32'(m_axis_tdest), 32'd1);
        drain();
        chk("postrst_cnt1", 32'(cnt_of(1)), 32'd1);
        chk("postrst_cnt3", 32'(cnt_of(3)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
